// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit: fetch/decode/execute/mem-wait/writeback sequencing with memory-ready handshake.
// Optional retired-instruction counter built only when CTRL_PERF_CNT_EN is defined.
module multicycle_ctrl #(
  parameter int OPCODE_W    = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                halt_req,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                ir_load,
  output logic                pc_enable,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                mem_sel,
  output logic                RegWrite,
  output logic                RegDst,
  output logic [2:0]          WBSrc,
  output logic                BSrc,
  output logic                ALUOp,
  output logic                ExtSel,
  output logic                NZ,
  output logic                PCSrc,
  output logic                BrSrc,
  output logic [1:0]          br_sel,
  output logic                busy,
  output logic                illegal,
  output logic                mem_timeout,
  output logic [CNT_W-1:0]    retired_cnt
);

  typedef enum logic [2:0] {
    IDLE, FETCH, FETCH_WAIT, DECODE, EXECUTE, MEM_WAIT, WRITEBACK, HALT
  } state_t;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;

  logic [OPCODE_W-1:0] opHigh;
  logic [4:0]          op5;
  logic                decLegal, decRegWrite, decRegDst, decBSrc, decALUOp;
  logic                decExtSel, decNZ, decPCSrc, decBrSrc, decLd, decSt;
  logic [2:0]          decWBSrc;
  logic [1:0]          decBrSel;

  assign opHigh = opcode >> 5;
  assign op5    = opcode[4:0];

  always_comb begin
    decLegal    = 1'b1;
    decRegWrite = 1'b0;
    decRegDst   = 1'b0;
    decWBSrc    = 3'b001;
    decBSrc     = 1'b0;
    decALUOp    = 1'b0;
    decExtSel   = 1'b0;
    decNZ       = 1'b0;
    decPCSrc    = 1'b0;
    decBrSrc    = 1'b0;
    decBrSel    = 2'd0;
    decLd       = 1'b0;
    decSt       = 1'b0;
    case (op5)
      5'b00000: begin decRegWrite = 1'b1; decWBSrc = 3'b011; end
      5'b00001: begin decRegWrite = 1'b1; decNZ = 1'b1; end
      5'b10001: begin decRegWrite = 1'b1; decNZ = 1'b1; decBSrc = 1'b1; end
      5'b00010: begin decRegWrite = 1'b1; decNZ = 1'b1; decALUOp = 1'b1; end
      5'b10010: begin decRegWrite = 1'b1; decNZ = 1'b1; decALUOp = 1'b1; decBSrc = 1'b1; end
      5'b00011: begin decNZ = 1'b1; decALUOp = 1'b1; end
      5'b10011: begin decNZ = 1'b1; decALUOp = 1'b1; decBSrc = 1'b1; end
      5'b00100: begin decRegWrite = 1'b1; decWBSrc = 3'b000; decLd = 1'b1; end
      5'b00101: decSt = 1'b1;
      5'b10000: begin decRegWrite = 1'b1; decWBSrc = 3'b100; decBSrc = 1'b1; end
      5'b10110: begin decRegWrite = 1'b1; decWBSrc = 3'b101; decBSrc = 1'b1; end
      5'b01000: decPCSrc = 1'b1;
      5'b01001: begin decPCSrc = 1'b1; decBrSel = 2'd1; end
      5'b01010: begin decPCSrc = 1'b1; decBrSel = 2'd2; end
      5'b01100: begin
        decPCSrc = 1'b1; decRegWrite = 1'b1; decRegDst = 1'b1; decWBSrc = 3'b010;
      end
      5'b11000: begin decPCSrc = 1'b1; decBrSrc = 1'b1; decExtSel = 1'b1; end
      5'b11001: begin decPCSrc = 1'b1; decBrSrc = 1'b1; decExtSel = 1'b1; decBrSel = 2'd1; end
      5'b11010: begin decPCSrc = 1'b1; decBrSrc = 1'b1; decExtSel = 1'b1; decBrSel = 2'd2; end
      5'b11100: begin
        decPCSrc = 1'b1; decBrSrc = 1'b1; decExtSel = 1'b1;
        decRegWrite = 1'b1; decRegDst = 1'b1; decWBSrc = 3'b010;
      end
      default: decLegal = 1'b0;
    endcase
    if (opHigh != '0) decLegal = 1'b0;
  end

  // Both wait states share one counter; mem_ready on the last allowed cycle still wins.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE:      if (start) state_d = FETCH;
      FETCH:     begin state_d = FETCH_WAIT; waitCnt_d = '0; end
      FETCH_WAIT, MEM_WAIT: begin
        if (mem_ready) begin
          state_d = (state_q == FETCH_WAIT) ? DECODE : WRITEBACK;
        end else if (waitCnt_q == WAIT_LAST) begin
          state_d   = HALT;
          timeout_d = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      DECODE: begin
        if (decLegal) begin
          state_d = EXECUTE;
        end else begin
          state_d   = HALT;
          illegal_d = 1'b1;
        end
      end
      EXECUTE: begin
        if (decLd || decSt) begin
          state_d   = MEM_WAIT;
          waitCnt_d = '0;
        end else begin
          state_d = WRITEBACK;
        end
      end
      WRITEBACK: state_d = halt_req ? IDLE : FETCH;
      HALT:      state_d = HALT;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      waitCnt_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    ir_load   = 1'b0;
    pc_enable = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    mem_sel   = 1'b0;
    RegWrite  = 1'b0;
    RegDst    = 1'b0;
    WBSrc     = 3'b001;
    BSrc      = 1'b0;
    ALUOp     = 1'b0;
    ExtSel    = 1'b0;
    NZ        = 1'b0;
    PCSrc     = 1'b0;
    BrSrc     = 1'b0;
    br_sel    = 2'd0;
    case (state_q)
      FETCH:      MemRead = 1'b1;
      FETCH_WAIT: begin MemRead = 1'b1; ir_load = mem_ready; end
      EXECUTE: begin
        ALUOp    = decALUOp;
        BSrc     = decBSrc;
        ExtSel   = decExtSel;
        NZ       = decNZ;
        MemRead  = decLd;
        MemWrite = decSt;
        mem_sel  = decLd | decSt;
      end
      MEM_WAIT: begin
        MemRead  = decLd;
        MemWrite = decSt;
        mem_sel  = 1'b1;
      end
      // ExtSel stays live here so the PC-relative target uses the imm11 extension.
      WRITEBACK: begin
        pc_enable = 1'b1;
        RegWrite  = decRegWrite;
        RegDst    = decRegDst;
        WBSrc     = decWBSrc;
        PCSrc     = decPCSrc;
        BrSrc     = decBrSrc;
        br_sel    = decBrSel;
        ExtSel    = decExtSel;
      end
      default: ;
    endcase
  end

  assign busy        = (state_q != IDLE) && (state_q != HALT);
  assign illegal     = illegal_q;
  assign mem_timeout = timeout_q;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] retCnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      retCnt_q <= '0;
    end else if (state_q == WRITEBACK) begin
      retCnt_q <= retCnt_q + 1'b1;
    end
  end

  assign retired_cnt = retCnt_q;
`else
  assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: retirements are checked by a monitor against queued expectations,
// while directed per-cycle checks cover strobes, flags, halting and reset.
module tb_multicycle_ctrl;

  localparam int OPW = 6;
  localparam int TMO = 4;
  localparam int CW  = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic           halt_req = 1'b0;
  logic [OPW-1:0] opcode = '0;
  logic           mem_ready = 1'b0;
  logic           ir_load, pc_enable, MemRead, MemWrite, mem_sel;
  logic           RegWrite, RegDst, BSrc, ALUOp, ExtSel, NZ, PCSrc, BrSrc;
  logic [2:0]     WBSrc;
  logic [1:0]     br_sel;
  logic           busy, illegal, mem_timeout;
  logic [CW-1:0]  retired_cnt;

  typedef struct {
    int         cyc;
    logic [9:0] ctrl;
    string      name;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cycleQ = 0;

  logic [OPW-1:0] ops [5];
  logic [9:0]     ctrls [5];

  multicycle_ctrl #(.OPCODE_W(OPW), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .opcode(opcode),
    .mem_ready(mem_ready), .ir_load(ir_load), .pc_enable(pc_enable), .MemRead(MemRead),
    .MemWrite(MemWrite), .mem_sel(mem_sel), .RegWrite(RegWrite), .RegDst(RegDst),
    .WBSrc(WBSrc), .BSrc(BSrc), .ALUOp(ALUOp), .ExtSel(ExtSel), .NZ(NZ), .PCSrc(PCSrc),
    .BrSrc(BrSrc), .br_sel(br_sel), .busy(busy), .illegal(illegal),
    .mem_timeout(mem_timeout), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleQ <= cycleQ + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] ctl(input logic rw, input logic rd, input logic [2:0] wb,
                                      input logic pcs, input logic brs, input logic ext,
                                      input logic [1:0] br);
    return {rw, rd, wb, pcs, brs, ext, br};
  endfunction

  function automatic int expCnt(input int n);
`ifdef CTRL_PERF_CNT_EN
    return n % (1 << CW);
`else
    return 0 * n;
`endif
  endfunction

  task automatic nextCycle(input logic st, input logic mr, input logic hr, input logic rn);
    @(posedge clk);
    #1;
    start     = st;
    mem_ready = mr;
    halt_req  = hr;
    reset     = rn;
    @(negedge clk);
  endtask

  // Raises start in IDLE; returns the cycle stamp so FETCH lands on c+1.
  task automatic applyStimulus(input logic [OPW-1:0] op, input logic hr, output int c);
    @(posedge clk);
    #1;
    opcode    = op;
    start     = 1'b1;
    halt_req  = hr;
    mem_ready = 1'b1;
    c         = cycleQ;
  endtask

  task automatic expectRetire(input string name, input int cyc, input logic [9:0] ctrl);
    exp_t e;
    e.name = name;
    e.cyc  = cyc;
    e.ctrl = ctrl;
    sbQ.push_back(e);
  endtask

  task automatic resetDut();
    nextCycle(1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle(1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic runIllegal(input string name, input logic [OPW-1:0] op);
    int c;
    applyStimulus(op, 1'b1, c);
    for (int j = 1; j <= 7; j++) begin
      nextCycle(j >= 5, 1'b1, 1'b1, 1'b1);
      if (j == 3) checkOutput({name, " decode"}, {illegal, busy}, 2'b01);
      if (j == 4) checkOutput({name, " halted"}, {illegal, busy}, 2'b10);
      if (j == 7) checkOutput({name, " start ignored"}, {illegal, busy}, 2'b10);
    end
    resetDut();
    checkOutput({name, " cleared"}, {illegal, busy}, 2'b00);
  endtask

  // Monitor: every pc_enable cycle must match the oldest queued retirement.
  initial begin
    forever begin
      @(negedge clk);
      if (pc_enable === 1'b1) begin
        checkOutput("retire expected", sbQ.size() > 0, 1);
        if (sbQ.size() > 0) begin
          exp_t e;
          e = sbQ.pop_front();
          checkOutput({e.name, " retire cycle"}, cycleQ, e.cyc);
          checkOutput({e.name, " wb controls"},
                      {RegWrite, RegDst, WBSrc, PCSrc, BrSrc, ExtSel, br_sel}, e.ctrl);
        end
      end
    end
  end

  initial begin
    int c;
    ops[0] = 6'b000000; ctrls[0] = ctl(1, 0, 3'b011, 0, 0, 0, 2'd0);
    ops[1] = 6'b010001; ctrls[1] = ctl(1, 0, 3'b001, 0, 0, 0, 2'd0);
    ops[2] = 6'b001010; ctrls[2] = ctl(0, 0, 3'b001, 1, 0, 0, 2'd2);
    ops[3] = 6'b011001; ctrls[3] = ctl(0, 0, 3'b001, 1, 1, 1, 2'd1);
    ops[4] = 6'b010110; ctrls[4] = ctl(1, 0, 3'b101, 0, 0, 0, 2'd0);

    resetDut();
    checkOutput("reset busy", busy, 0);
    checkOutput("reset flags", {illegal, mem_timeout}, 2'b00);
    checkOutput("reset retired_cnt", retired_cnt, 0);
    checkOutput("reset defaults", {pc_enable, MemRead, MemWrite, RegWrite, WBSrc}, 7'b0000001);

    // add with immediate memory ready
    applyStimulus(6'b000001, 1'b1, c);
    expectRetire("add", c + 5, ctl(1, 0, 3'b001, 0, 0, 0, 2'd0));
    for (int j = 1; j <= 7; j++) begin
      nextCycle(1'b0, 1'b1, 1'b1, 1'b1);
      if (j == 1) checkOutput("add fetch", {MemRead, mem_sel, busy}, 3'b101);
      if (j == 2) checkOutput("add ir_load", ir_load, 1);
      if (j == 4) checkOutput("add exec alu", {NZ, ALUOp, BSrc, ExtSel}, 4'b1000);
      if (j == 7) begin
        checkOutput("add idle", busy, 0);
        checkOutput("add retired_cnt", retired_cnt, expCnt(1));
      end
    end

    // ld with three not-ready MEM_WAIT cycles
    applyStimulus(6'b000100, 1'b1, c);
    expectRetire("ld", c + 9, ctl(1, 0, 3'b000, 0, 0, 0, 2'd0));
    for (int j = 1; j <= 11; j++) begin
      nextCycle(1'b0, !(j >= 5 && j <= 7), 1'b1, 1'b1);
      if (j >= 5 && j <= 8) checkOutput("ld memwait strobes", {MemRead, MemWrite, mem_sel}, 3'b101);
      if (j == 11) begin
        checkOutput("ld idle", busy, 0);
        checkOutput("ld retired_cnt", retired_cnt, expCnt(2));
      end
    end

    runIllegal("illegal 01111", 6'b001111);
    runIllegal("illegal high bit", 6'b100001);

    // fetch timeout: mem_ready never arrives
    applyStimulus(6'b000001, 1'b1, c);
    for (int j = 1; j <= 7; j++) begin
      nextCycle(1'b0, 1'b0, 1'b1, 1'b1);
      if (j == 5) checkOutput("timeout 4th wait", {mem_timeout, busy}, 2'b01);
      if (j == 6) checkOutput("timeout halted", {mem_timeout, busy}, 2'b10);
    end
    resetDut();
    checkOutput("timeout cleared", mem_timeout, 0);

    // ready on the last allowed wait cycle
    applyStimulus(6'b000010, 1'b1, c);
    expectRetire("sub late ready", c + 8, ctl(1, 0, 3'b001, 0, 0, 0, 2'd0));
    for (int j = 1; j <= 10; j++) begin
      nextCycle(1'b0, !(j >= 2 && j <= 4), 1'b1, 1'b1);
      if (j == 5) checkOutput("late ready ir_load", ir_load, 1);
      if (j == 7) checkOutput("sub exec alu", {NZ, ALUOp, BSrc, ExtSel}, 4'b1100);
      if (j == 10) begin
        checkOutput("late ready no timeout", {mem_timeout, busy}, 2'b00);
        checkOutput("sub retired_cnt", retired_cnt, expCnt(1));
      end
    end

    // call with halt_req in writeback
    applyStimulus(6'b011100, 1'b1, c);
    expectRetire("call", c + 5, ctl(1, 1, 3'b010, 1, 1, 1, 2'd0));
    for (int j = 1; j <= 6; j++) begin
      nextCycle(1'b0, 1'b1, 1'b1, 1'b1);
      if (j == 6) begin
        checkOutput("call idle", busy, 0);
        checkOutput("call retired_cnt", retired_cnt, expCnt(2));
      end
    end

    // st interrupted by reset in MEM_WAIT
    applyStimulus(6'b000101, 1'b1, c);
    for (int j = 1; j <= 8; j++) begin
      nextCycle(1'b0, j < 5, 1'b1, j != 6);
      if (j == 5 || j == 6) checkOutput("st memwait strobes", {MemRead, MemWrite, mem_sel}, 3'b011);
      if (j == 7) checkOutput("st dropped by reset", {MemWrite, busy}, 2'b00);
      if (j == 8) checkOutput("st reset retired_cnt", retired_cnt, 0);
    end

    // five back-to-back instructions, counter wraps at CNT_W = 2
    applyStimulus(ops[0], 1'b0, c);
    for (int k = 0; k < 5; k++) expectRetire($sformatf("seq%0d", k), c + 5 * (k + 1), ctrls[k]);
    for (int j = 1; j <= 27; j++) begin
      nextCycle(1'b0, 1'b1, j >= 21, 1'b1);
      if (j > 1 && j % 5 == 1) opcode = ops[j / 5];
      if (j == 27) begin
        checkOutput("seq idle", busy, 0);
        checkOutput("seq retired_cnt wrap", retired_cnt, expCnt(5));
      end
    end

    nextCycle(1'b0, 1'b1, 1'b0, 1'b1);
    nextCycle(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("scoreboard drained", sbQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
